// File: rtl/calc_disp_pkg.sv
// Shared display constants for the calculator's 7-segment output path.
// All segment and anode encodings are active-low.
package calc_disp_pkg;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    // Bit order within each pattern is {g,f,e,d,c,b,a}; entry 0 is the rightmost element.
    localparam logic [9:0][6:0] SEG_DIGITS = {
        7'b0010000,  // 9
        7'b0000000,  // 8
        7'b1111000,  // 7
        7'b0000010,  // 6
        7'b0010010,  // 5
        7'b0011001,  // 4
        7'b0110000,  // 3
        7'b0100100,  // 2
        7'b1111001,  // 1
        7'b1000000   // 0
    };

    localparam logic [3:0]      ANODE_OFF  = 4'b1111;
    localparam logic [3:0][3:0] ANODE_SLOT = {4'b1110, 4'b1101, 4'b1011, 4'b0111};

    typedef enum logic [1:0] {
        SLOT_D1 = 2'd0,
        SLOT_D2 = 2'd1,
        SLOT_D3 = 2'd2,
        SLOT_D4 = 2'd3
    } slot_t;

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD to active-low 7-segment decoder.
// Non-decimal codes 10-15 produce a dark digit.
module bcd_to_seg
    import calc_disp_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (bcd <= 4'd9) begin
            seg = SEG_DIGITS[bcd];
        end
    end

endmodule

// File: rtl/seven_seg_scanner.sv
// Four-digit multiplexed 7-segment scanner with leading-zero blanking and a
// one-shot frame_done handshake after the first complete scan of each load.
module seven_seg_scanner
    import calc_disp_pkg::*;
#(
    parameter int REFRESH_DIV   = 100000,
    parameter bit BLANK_LEADING = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [3:0] digit1,
    input  logic [3:0] digit2,
    input  logic [3:0] digit3,
    input  logic [3:0] digit4,
    input  logic       err,
    output logic [3:0] anode,
    output logic [6:0] seg,
    output logic       dp,
    output logic       frame_done
);

    localparam int PW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);

    logic [3:0]    hold1_p0, hold2_p0, hold3_p0, hold4_p0;
    logic          err_p0;
    logic [PW-1:0] prescaler;
    slot_t         slot;
    logic          pending;
    logic          tick;

    logic [3:0]    digit_sel;
    logic          lead_zero;
    logic          blank;
    logic [6:0]    seg_dec;
    logic [3:0]    anode_nxt;
    logic [6:0]    seg_nxt;

    logic [3:0]    anode_p1;
    logic [6:0]    seg_p1;
    logic          frame_done_p1;

    assign tick = (prescaler == PRESC_LAST);

    // Stage p0: capture, prescaler and slot sequencing
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold1_p0  <= '0;
            hold2_p0  <= '0;
            hold3_p0  <= '0;
            hold4_p0  <= '0;
            err_p0    <= 1'b0;
            prescaler <= '0;
            slot      <= SLOT_D1;
            pending   <= 1'b0;
        end else if (load) begin
            hold1_p0  <= digit1;
            hold2_p0  <= digit2;
            hold3_p0  <= digit3;
            hold4_p0  <= digit4;
            err_p0    <= err;
            prescaler <= '0;
            slot      <= SLOT_D1;
            pending   <= 1'b1;
        end else if (tick) begin
            prescaler <= '0;
            slot      <= slot_t'(slot + 2'd1);
            if (slot == SLOT_D4) begin
                pending <= 1'b0;
            end
        end else begin
            prescaler <= prescaler + PW'(1);
        end
    end

    always_comb begin
        digit_sel = hold4_p0;
        lead_zero = 1'b0;
        unique case (slot)
            SLOT_D1: begin
                digit_sel = hold1_p0;
                lead_zero = (hold1_p0 == 4'd0);
            end
            SLOT_D2: begin
                digit_sel = hold2_p0;
                lead_zero = (hold1_p0 == 4'd0) && (hold2_p0 == 4'd0);
            end
            SLOT_D3: begin
                digit_sel = hold3_p0;
                lead_zero = (hold1_p0 == 4'd0) && (hold2_p0 == 4'd0) && (hold3_p0 == 4'd0);
            end
            SLOT_D4: begin
                digit_sel = hold4_p0;
                lead_zero = 1'b0;
            end
            default: ;
        endcase
    end

    bcd_to_seg u_dec (
        .bcd (digit_sel),
        .seg (seg_dec)
    );

    // The error dash overrides blanking so every position shows a dash.
    always_comb begin
        blank     = BLANK_LEADING && !err_p0 && lead_zero;
        anode_nxt = blank ? ANODE_OFF : ANODE_SLOT[slot];
        seg_nxt   = seg_dec;
        if (err_p0) begin
            seg_nxt = SEG_DASH;
        end else if (blank) begin
            seg_nxt = SEG_BLANK;
        end
    end

    // Stage p1: registered display drive and handshake pulse
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            anode_p1      <= ANODE_OFF;
            seg_p1        <= SEG_BLANK;
            frame_done_p1 <= 1'b0;
        end else begin
            anode_p1      <= anode_nxt;
            seg_p1        <= seg_nxt;
            frame_done_p1 <= tick && !load && pending && (slot == SLOT_D4);
        end
    end

    assign anode      = anode_p1;
    assign seg        = seg_p1;
    assign dp         = 1'b1;
    assign frame_done = frame_done_p1;

endmodule
